// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B (mod 2^WIDTH) and final BORROW,
// one bit per clock LSB first, behind a START/DONE handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_a_s;
  logic             bit_b_s;
  logic             d_bit_s;
  logic             bout_s;

  // Full-subtractor cell, next-state logic and registered-output decode
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    bit_a_s = a_sh_q[0];
    bit_b_s = b_sh_q[0];
    d_bit_s = bit_a_s ^ bit_b_s ^ br_q;
    bout_s  = (~bit_a_s & bit_b_s) | (~(bit_a_s ^ bit_b_s) & br_q);

    case (state_q)
      IDLE: begin
        if (START) begin
          a_sh_d  = A;
          b_sh_d  = B;
          d_sh_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // New difference bit enters at the MSB so the word ends LSB-aligned
        d_sh_d            = d_sh_q >> 1;
        d_sh_d[WIDTH-1]   = d_bit_s;
        br_d   = bout_s;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          diff_d   = d_sh_d;
          borrow_d = bout_s;
          state_d  = FINISH;
        end else begin
          state_d  = SHIFT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == FINISH);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model (A-B mod 2^W, A<B) with randomized operands.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int         checks;
  int         failures;
  logic       use_w1;
  logic [7:0] last_diff8;
  logic [7:0] last_diff1;

  logic       cur_busy, cur_done, cur_borrow;
  logic [7:0] cur_diff;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BORROW(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1),
    .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BORROW(borrow1)
  );

  assign cur_busy   = use_w1 ? busy1   : busy8;
  assign cur_done   = use_w1 ? done1   : done8;
  assign cur_borrow = use_w1 ? borrow1 : borrow8;
  assign cur_diff   = use_w1 ? {7'd0, diff1} : diff8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: START at the next edge, then timing and result checks
  task automatic do_op(input logic w1, input logic [7:0] a, input logic [7:0] b,
                       input bit hold_start, input bit scramble);
    int         w;
    int         edges;
    int         busy_cnt;
    logic [7:0] mask;
    logic [7:0] exp_d;
    logic       exp_b;
    logic [7:0] prev;
    w      = w1 ? 1 : 8;
    mask   = w1 ? 8'h01 : 8'hFF;
    exp_d  = (a - b) & mask;
    exp_b  = ((a & mask) < (b & mask));
    use_w1 = w1;
    prev   = w1 ? last_diff1 : last_diff8;
    if (w1) begin
      a1 = a[0:0]; b1 = b[0:0]; start1 = 1'b1;
    end else begin
      a8 = a; b8 = b; start8 = 1'b1;
    end
    step();
    if (!hold_start) begin
      start1 = 1'b0;
      start8 = 1'b0;
    end
    edges    = 0;
    busy_cnt = 0;
    while (!cur_done && edges < 40) begin
      if (cur_busy) busy_cnt++;
      check_eq("diff_hold", {24'd0, cur_diff}, {24'd0, prev});
      if (scramble && edges == 0) begin
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        a1 = 1'($urandom_range(0, 1));
        b1 = 1'($urandom_range(0, 1));
      end
      step();
      edges++;
    end
    check_eq("done_latency", edges, w);
    check_eq("busy_cycles", busy_cnt, w);
    check_eq("busy_in_finish", {31'd0, cur_busy}, 32'd0);
    check_eq("diff", {24'd0, cur_diff}, {24'd0, exp_d});
    check_eq("borrow", {31'd0, cur_borrow}, {31'd0, exp_b});
    if (w1) last_diff1 = exp_d;
    else    last_diff8 = exp_d;
    step();
    check_eq("done_pulse", {31'd0, cur_done}, 32'd0);
    check_eq("idle_busy", {31'd0, cur_busy}, 32'd0);
  endtask

  initial begin
    int done_seen;
    checks = 0; failures = 0;
    use_w1 = 1'b0;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; a1 = 1'b0; b1 = 1'b0;
    last_diff8 = 8'd0; last_diff1 = 8'd0;
    step(); step(); step();
    rst = 1'b0;
    check_eq("rst_busy8", {31'd0, busy8}, 32'd0);
    check_eq("rst_done8", {31'd0, done8}, 32'd0);
    check_eq("rst_diff8", {24'd0, diff8}, 32'd0);
    check_eq("rst_borrow8", {31'd0, borrow8}, 32'd0);
    check_eq("rst_busy1", {31'd0, busy1}, 32'd0);
    check_eq("rst_diff1", {31'd0, diff1}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 8'(i >> 1), 8'(i & 1), 1'b0, 1'b1);
    end

    do_op(1'b0, 8'h05, 8'h03, 1'b0, 1'b0);
    do_op(1'b0, 8'h03, 8'h05, 1'b0, 1'b1);
    do_op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
    do_op(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    do_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b1);

    // START held high: the next op starts at the first IDLE edge
    do_op(1'b0, 8'h10, 8'h01, 1'b1, 1'b1);
    do_op(1'b0, 8'h20, 8'h02, 1'b0, 1'b0);

    do_op(1'b0, 8'h03, 8'h05, 1'b0, 1'b0);
    use_w1 = 1'b0;
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    check_eq("pre_rst_busy", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, busy8}, 32'd0);
    check_eq("midrst_done", {31'd0, done8}, 32'd0);
    check_eq("midrst_diff", {24'd0, diff8}, 32'd0);
    check_eq("midrst_borrow", {31'd0, borrow8}, 32'd0);
    last_diff8 = 8'd0;
    last_diff1 = 8'd0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) done_seen++;
      step();
    end
    check_eq("no_done_after_rst", done_seen, 0);
    do_op(1'b0, 8'h05, 8'h03, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      do_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
